// File: rtl/serdes_tx_serializer.sv
// Transmit serializer: training burst (clock pattern or PRBS7) after reset or on request,
// then handshaked data symbols sent LSB-first with idle fill so the line never stalls.
module serdes_tx_serializer #(
   parameter int unsigned      WIDTH         = 10,
   parameter int unsigned      TRAIN_SYMBOLS = 64,
   parameter logic [WIDTH-1:0] IDLE_PATTERN  = 10'b0101111100,
   parameter logic [6:0]       PRBS_SEED     = 7'h7F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             prbs_en,
   input  logic             train_start,
   output logic             serial_out,
   output logic             sym_strobe,
   output logic [1:0]       state
);
   localparam int unsigned    BCW        = $clog2(WIDTH);
   localparam int unsigned    TCW        = $clog2(TRAIN_SYMBOLS + 1);
   localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);
   localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_SYMBOLS);

   typedef enum logic [1:0] {
      TRAIN = 2'd0,
      DATA  = 2'd1
   } state_t;

   state_t           cur_state, nxt_state;
   logic [BCW-1:0]   bit_cnt;
   logic [TCW-1:0]   train_cnt;
   logic [WIDTH-1:0] hold, shreg, train_sym, load_sym;
   logic             hold_full, train_pend;
   logic [6:0]       lfsr, lfsr_adv;
   logic             boundary, xfer, load_train, use_hold, capture;

   assign boundary = (bit_cnt == BIT_LAST);
   assign tx_ready = (cur_state == DATA) && !hold_full;
   assign xfer     = tx_valid && tx_ready;
   assign state    = cur_state;

   // Training symbol and the LFSR value after WIDTH PRBS7 steps.
   always_comb begin
      lfsr_adv  = lfsr;
      train_sym = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (prbs_en) begin
            train_sym[i] = lfsr_adv[6] ^ lfsr_adv[5];
            lfsr_adv     = {lfsr_adv[5:0], lfsr_adv[6] ^ lfsr_adv[5]};
         end else begin
            train_sym[i] = ~i[0];
         end
      end
   end

   always_comb begin
      nxt_state  = cur_state;
      load_train = 1'b0;
      use_hold   = 1'b0;
      load_sym   = IDLE_PATTERN;
      if (boundary) begin
         case (cur_state)
            TRAIN: begin
               if (train_cnt == TRAIN_LAST) nxt_state = DATA;
               else                         load_train = 1'b1;
            end
            DATA: begin
               if (train_pend) begin
                  nxt_state  = TRAIN;
                  load_train = 1'b1;
               end
            end
            default: begin
               nxt_state  = TRAIN;
               load_train = 1'b1;
            end
         endcase
         if (load_train) begin
            load_sym = train_sym;
         end else if (hold_full) begin
            load_sym = hold;
            use_hold = 1'b1;
         end else if (xfer) begin
            load_sym = tx_data;
         end
      end
   end

   // A transfer bypasses hold only when it is loaded straight into the serializer.
   assign capture = xfer && !(boundary && !load_train && !hold_full);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state  <= TRAIN;
         bit_cnt    <= BIT_LAST;
         train_cnt  <= '0;
         hold       <= '0;
         hold_full  <= 1'b0;
         train_pend <= 1'b0;
         lfsr       <= PRBS_SEED;
         shreg      <= '0;
         serial_out <= 1'b0;
         sym_strobe <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if (boundary) begin
            bit_cnt    <= '0;
            shreg      <= load_sym >> 1;
            serial_out <= load_sym[0];
            sym_strobe <= 1'b1;
            train_cnt  <= load_train ? train_cnt + TCW'(1) : '0;
            if (load_train && prbs_en) lfsr <= lfsr_adv;
         end else begin
            bit_cnt    <= bit_cnt + BCW'(1);
            shreg      <= shreg >> 1;
            serial_out <= shreg[0];
            sym_strobe <= 1'b0;
         end
         if (capture) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end else if (use_hold) begin
            hold_full <= 1'b0;
         end
         if (boundary && cur_state == DATA && train_pend) train_pend <= 1'b0;
         else if (cur_state == DATA && train_start)      train_pend <= 1'b1;
      end
   end
endmodule

// File: tb/tb_serdes_tx_serializer.sv
// Bench for serdes_tx_serializer: directed training/data sequences, a vector table,
// and randomized traffic checked every cycle against a symbol-level reference model.
module tb_serdes_tx_serializer;
   localparam int         W    = 10;
   localparam int         TS   = 64;
   localparam logic [9:0] IDLE = 10'h17C;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       prbs_en = 1'b0;
   logic       train_start = 1'b0;
   logic       serial_out;
   logic       sym_strobe;
   logic [1:0] state;

   serdes_tx_serializer #(
      .WIDTH(10), .TRAIN_SYMBOLS(64), .IDLE_PATTERN(10'b0101111100), .PRBS_SEED(7'h7F)
   ) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .prbs_en(prbs_en), .train_start(train_start), .serial_out(serial_out),
      .sym_strobe(sym_strobe), .state(state)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: bounded wait expired", name);
   endtask

   // PRBS7 reference stream (period 127) from the seed and feedback rule.
   bit prbs_bits[127];
   initial begin
      logic [6:0] l;
      l = 7'h7F;
      for (int k = 0; k < 127; k++) begin
         prbs_bits[k] = l[6] ^ l[5];
         l = {l[5:0], l[6] ^ l[5]};
      end
   end

   // Reference model: tracks which symbol is on the line and which bit of it is showing.
   bit         model_on = 1'b0;
   int         m_phase, m_count, m_ptr;
   bit         m_train, m_hold_v, m_pend;
   logic [9:0] m_cur, m_hold;
   bit         exp_serial, exp_strobe, exp_ready;
   int         exp_state;
   bit         m_xfer, m_start, m_retrain;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = W - 1; m_count = 0; m_ptr = 0;
         m_train = 1; m_hold_v = 0; m_pend = 0; m_cur = '0;
         exp_serial = 0; exp_strobe = 0;
      end else begin
         m_xfer    = tx_valid && !m_train && !m_hold_v;
         m_start   = train_start && !m_train;
         m_retrain = 0;
         if (m_phase == W - 1) begin
            if (m_train && m_count == TS) begin
               m_train = 0; m_count = 0;
            end else if (!m_train && m_pend) begin
               m_train = 1; m_pend = 0; m_retrain = 1;
            end
            if (m_train) begin
               for (int i = 0; i < W; i++)
                  m_cur[i] = prbs_en ? prbs_bits[(m_ptr + i) % 127] : ((i % 2) == 0);
               if (prbs_en) m_ptr = (m_ptr + W) % 127;
               m_count++;
               if (m_xfer) begin m_hold = tx_data; m_hold_v = 1; end
            end else if (m_hold_v) begin
               m_cur = m_hold; m_hold_v = 0;
            end else if (m_xfer) begin
               m_cur = tx_data;
            end else begin
               m_cur = IDLE;
            end
            m_phase = 0;
         end else begin
            m_phase++;
            if (m_xfer) begin m_hold = tx_data; m_hold_v = 1; end
         end
         if (m_start && !m_retrain) m_pend = 1;
         exp_serial = m_cur[m_phase];
         exp_strobe = (m_phase == 0);
      end
      exp_ready = !m_train && !m_hold_v;
      exp_state = m_train ? 0 : 1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("m_serial_out", serial_out, exp_serial);
         chk("m_sym_strobe", sym_strobe, exp_strobe);
         chk("m_tx_ready", tx_ready, exp_ready);
         chk("m_state", state, exp_state);
      end
   end

   logic [9:0] cap[66];

   task automatic get_sym(output logic [9:0] w, output logic [9:0] s, output bit rdy);
      rdy = 0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         w[i] = serial_out;
         s[i] = sym_strobe;
         if (tx_ready) rdy = 1;
      end
   endtask

   task automatic capture(input int n);
      int waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (sym_strobe !== 1'b1 && waited < 4 * W);
      if (sym_strobe !== 1'b1) fail_now("capture_strobe");
      for (int b = 0; b < n * W; b++) begin
         if (b > 0) @(negedge clk);
         cap[b / W][b % W] = serial_out;
      end
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      while (m_phase != p && n < 3 * W) begin
         @(negedge clk);
         n++;
      end
      if (m_phase != p) fail_now("wait_phase");
   endtask

   typedef struct {
      logic [9:0] word;
      int         phase;
      logic       exp_ready;
   } vec_t;
   vec_t vecs[6];

   initial begin
      logic [9:0] w, s, ref_sym;
      bit         rdy, any_rdy;
      int         bad, n;

      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

   initial begin
      logic [9:0] w, s, ref_sym;
      bit         rdy, any_rdy;
      int         bad, n;

      vecs[0] = '{10'h3A5, 4, 1'b0};
      vecs[1] = '{10'h0F0, 9, 1'b1};
      vecs[2] = '{10'h155, 0, 1'b0};
      vecs[3] = '{10'h2AA, 8, 1'b0};
      vecs[4] = '{10'h3FF, 9, 1'b1};
      vecs[5] = '{10'h001, 5, 1'b0};

      // Reset, clock-pattern training, then idle fill.
      repeat (5) @(negedge clk);
      model_on = 1;
      chk("rst_serial_out", serial_out, 0);
      chk("rst_sym_strobe", sym_strobe, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_state", state, 0);
      rst = 0;
      any_rdy = 0;
      for (int k = 0; k < TS; k++) begin
         get_sym(w, s, rdy);
         chk("train_clk_sym", w, 10'h155);
         chk("train_strobe", s, 10'h001);
         any_rdy |= rdy;
      end
      chk("train_ready_low", any_rdy, 0);
      get_sym(w, s, rdy);
      chk("idle_after_train", w, IDLE);
      chk("data_state", state, 1);

      // PRBS7 training.
      rst = 1; prbs_en = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      for (int k = 0; k < TS; k++) begin
         get_sym(w, s, rdy);
         for (int i = 0; i < W; i++) ref_sym[i] = prbs_bits[(k * W + i) % 127];
         if (k == 0) chk("prbs_first_sym", w, 10'h040);
         chk("prbs_sym", w, ref_sym);
      end
      get_sym(w, s, rdy);
      chk("prbs_then_idle", w, IDLE);

      // Vector table: single transfers at various symbol phases.
      foreach (vecs[v]) begin
         wait_phase(vecs[v].phase);
         tx_valid = 1; tx_data = vecs[v].word;
         fork
            capture(2);
            begin
               @(negedge clk);
               tx_valid = 0;
               chk("vec_ready_after", tx_ready, vecs[v].exp_ready);
            end
         join
         chk("vec_sym", cap[0], vecs[v].word);
         chk("vec_then_idle", cap[1], IDLE);
      end

      // Back-to-back words: one via hold, one queued behind it.
      wait_phase(3);
      tx_valid = 1; tx_data = 10'h3A5;
      fork
         capture(3);
         begin
            @(negedge clk);
            chk("t3_ready_low", tx_ready, 0);
            tx_data = 10'h0F0;
            n = 0;
            while (tx_ready !== 1'b1 && n < 4 * W) begin
               @(negedge clk);
               n++;
            end
            chk("t3_ready_return", tx_ready, 1);
            @(negedge clk);
            tx_valid = 0;
         end
      join
      chk("t3_first", cap[0], 10'h3A5);
      chk("t3_second", cap[1], 10'h0F0);
      chk("t3_idle", cap[2], IDLE);

      // Re-training with a word parked in hold; two pulses collapse into one burst.
      prbs_en = 0;
      wait_phase(2);
      tx_valid = 1; tx_data = 10'h2AA;
      @(negedge clk);
      tx_valid = 0;
      chk("t5_hold_full", tx_ready, 0);
      @(negedge clk); train_start = 1;
      @(negedge clk); train_start = 0;
      @(negedge clk); train_start = 1;
      @(negedge clk); train_start = 0;
      capture(66);
      bad = 0;
      for (int k = 0; k < TS; k++) if (cap[k] !== 10'h155) bad++;
      chk("t5_train_syms", bad, 0);
      chk("t5_held_word", cap[64], 10'h2AA);
      chk("t5_then_idle", cap[65], IDLE);

      // Reset in the middle of a data symbol, with a word in hold.
      wait_phase(9);
      tx_valid = 1; tx_data = 10'h3C3;
      @(negedge clk);
      tx_data = 10'h0F0;
      @(negedge clk);
      tx_valid = 0;
      chk("t6_hold_full", tx_ready, 0);
      repeat (3) @(negedge clk);
      chk("t6_at_bit4", m_phase, 4);
      rst = 1; prbs_en = 1;
      @(negedge clk);
      chk("t6_rst_serial", serial_out, 0);
      chk("t6_rst_ready", tx_ready, 0);
      chk("t6_rst_state", state, 0);
      rst = 0;
      for (int k = 0; k < TS; k++) begin
         get_sym(w, s, rdy);
         if (k == 0) chk("t6_restart_sym", w, 10'h040);
      end
      get_sym(w, s, rdy);
      chk("t6_hold_discarded", w, IDLE);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         tx_valid    = ($urandom_range(0, 2) != 0);
         tx_data     = 10'($urandom);
         prbs_en     = 1'($urandom_range(0, 1));
         train_start = ($urandom_range(0, 399) == 0);
         rst         = ($urandom_range(0, 1999) == 0);
         @(negedge clk);
      end
      tx_valid = 0; train_start = 0; rst = 0;
      repeat (3 * W) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
